// File: rtl/dec2bin_pkg.sv
// rtl/dec2bin_pkg.sv - shared constants and index helper for the decimal-to-binary encoder
//
// Purpose
//    Default geometry of the encoder and the priority-index helper used by the
//    top level to turn a line vector into the code of its highest set line.
// Contents
//    DEC_N_IN       default number of decimal input lines (10)
//    DEC_OUT_W      default output code width (4)
//    DEC_MAX_LINES  widest line vector onehot_index() accepts
//    DEC_IDX_W      width of the index onehot_index() returns
//    onehot_index() index of the highest set line, 0 when no line is set

package dec2bin_pkg;

   localparam int DEC_N_IN      = 10;
   localparam int DEC_OUT_W     = 4;
   localparam int DEC_MAX_LINES = 16;
   localparam int DEC_IDX_W     = 4;

   // Scans upward so a later (higher) set line overwrites an earlier one. For a
   // legal one-hot vector this is simply the position of the only set line.
   function automatic logic [DEC_IDX_W-1:0] onehot_index(input logic [DEC_MAX_LINES-1:0] lines);
      logic [DEC_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < DEC_MAX_LINES; i++) begin
         if (lines[i]) begin
            idx = DEC_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/dec2bin_onehot_check.sv
// rtl/dec2bin_onehot_check.sv - combinational legality flags for a decimal line vector
//
// Purpose
//    Classifies the decimal input lines as empty, single-hot or multi-hot.
// Ports
//    Decimal  in   N_IN  decimal digit lines
//    zero     out  1     no line is set
//    multi    out  1     two or more lines are set

module dec2bin_onehot_check
   import dec2bin_pkg::*;
#(
   parameter int N_IN = DEC_N_IN
) (
   input  logic [N_IN-1:0] Decimal,
   output logic            zero,
   output logic            multi
);

   // Clearing the lowest set bit leaves something only if a second bit was set.
   logic [N_IN-1:0] low_cleared;

   assign low_cleared = Decimal & (Decimal - N_IN'(1));
   assign zero        = ~|Decimal;
   assign multi       = |low_cleared;

endmodule

// File: rtl/decimal2binary_encoder.sv
// rtl/decimal2binary_encoder.sv - registered 10-line to BCD encoder with error flag
//
// Purpose
//    Converts a one-hot decimal digit vector into its binary code, one clock of
//    latency. Illegal inputs raise err instead of valid. With PRIORITY=1 a
//    multi-hot input is accepted and the highest set line wins.
// Ports
//    clk      in   1      rising-edge clock
//    rst      in   1      synchronous active-high reset, overrides Decimal
//    Decimal  in   N_IN   decimal digit lines
//    Binary   out  OUT_W  registered code of the active digit
//    valid    out  1      Binary holds a legal encoding
//    err      out  1      input had no line set, or several in strict mode

module decimal2binary_encoder
   import dec2bin_pkg::*;
#(
   parameter int N_IN     = DEC_N_IN,
   parameter int OUT_W    = DEC_OUT_W,
   parameter int PRIORITY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  Decimal,
   output logic [OUT_W-1:0] Binary,
   output logic             valid,
   output logic             err
);

   generate
      if (N_IN < 2) begin : g_too_few
         $error("decimal2binary_encoder: N_IN must be at least 2");
      end
      if (N_IN > (2 ** OUT_W)) begin : g_too_narrow
         $error("decimal2binary_encoder: OUT_W too narrow for N_IN lines");
      end
      if (N_IN > DEC_MAX_LINES) begin : g_too_wide
         $error("decimal2binary_encoder: N_IN exceeds onehot_index() capacity");
      end
   endgenerate

   logic                    zero;
   logic                    multi;
   logic [DEC_MAX_LINES-1:0] lines;
   logic [DEC_IDX_W-1:0]    idx;
   logic [OUT_W-1:0]        binary_d;
   logic                    valid_d;
   logic                    err_d;

   dec2bin_onehot_check #(
      .N_IN (N_IN)
   ) u_check (
      .Decimal (Decimal),
      .zero    (zero),
      .multi   (multi)
   );

   // The width checks above guarantee the index fits OUT_W, so the resize
   // below never drops a set bit.
   always_comb begin
      lines    = DEC_MAX_LINES'(Decimal);
      idx      = onehot_index(lines);
      binary_d = '0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (zero) begin
         err_d = 1'b1;
      end else if (multi && (PRIORITY == 0)) begin
         err_d = 1'b1;
      end else begin
         binary_d = OUT_W'(idx);
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Binary <= '0;
         valid  <= 1'b0;
         err    <= 1'b0;
      end else begin
         Binary <= binary_d;
         valid  <= valid_d;
         err    <= err_d;
      end
   end

endmodule

// File: tb/tb_decimal2binary_encoder.sv
// tb/tb_decimal2binary_encoder.sv - self-checking bench for decimal2binary_encoder

module tb_decimal2binary_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] dec = '0;

   logic [3:0] bin0, bin1;
   logic       v0, v1, e0, e1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decimal2binary_encoder #(.N_IN(10), .OUT_W(4), .PRIORITY(0)) dut_strict (
      .clk     (clk),
      .rst     (rst),
      .Decimal (dec),
      .Binary  (bin0),
      .valid   (v0),
      .err     (e0)
   );

   decimal2binary_encoder #(.N_IN(10), .OUT_W(4), .PRIORITY(1)) dut_prio (
      .clk     (clk),
      .rst     (rst),
      .Decimal (dec),
      .Binary  (bin1),
      .valid   (v1),
      .err     (e1)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: counts set lines and finds the top one via floor(log2(v)).
   function automatic logic [5:0] model(input logic [9:0] v, input bit prio);
      int cnt;
      int top;
      cnt = $countones(v);
      if (cnt == 0) return {4'd0, 1'b0, 1'b1};
      if (cnt > 1 && !prio) return {4'd0, 1'b0, 1'b1};
      top = $clog2(int'(v) + 1) - 1;
      return {4'(top), 1'b1, 1'b0};
   endfunction

   logic [5:0] exp0, exp1;
   logic       model_en = 1'b0;
   logic       exp_rst  = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         exp0     <= '0;
         exp1     <= '0;
         exp_rst  <= 1'b1;
         model_en <= 1'b1;
      end else begin
         exp0    <= model(dec, 1'b0);
         exp1    <= model(dec, 1'b1);
         exp_rst <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (model_en) begin
         chk("model strict", {bin0, v0, e0}, exp0);
         chk("model prio",   {bin1, v1, e1}, exp1);
         if (!exp_rst) begin
            chk("exclusive strict", int'(v0 ^ e0), 1);
            chk("exclusive prio",   int'(v1 ^ e1), 1);
         end
      end
   end

   task automatic cyc(input logic [9:0] d, input logic r);
      dec = d;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [10:0] wide;
      int          off;

      cyc(10'h3FF, 1'b1);
      cyc(10'd1, 1'b1);
      chk("reset bin", bin0, 0);
      chk("reset valid", v0, 0);
      chk("reset err", e0, 0);

      for (int i = 0; i < 10; i++) begin
         cyc(10'(1 << i), 1'b0);
         chk("walk bin", bin0, i);
         chk("walk valid", v0, 1);
         chk("walk err", e0, 0);
      end

      wide = 11'd1024;
      cyc(wide[9:0], 1'b0);
      chk("zero strict", {bin0, v0, e0}, 6'b0000_01);
      chk("zero prio",   {bin1, v1, e1}, 6'b0000_01);

      cyc(10'b00_0001_0010, 1'b0);
      chk("multi strict", {bin0, v0, e0}, 6'b0000_01);
      chk("multi prio",   {bin1, v1, e1}, 6'b0100_10);

      cyc(10'd256, 1'b1);
      chk("mid reset", {bin0, v0, e0}, 0);
      cyc(10'd256, 1'b0);
      chk("after reset bin", bin0, 8);
      chk("after reset valid", v0, 1);

      cyc(10'd8, 1'b0);
      chk("latency before", bin0, 3);
      dec = 10'd64;
      #3;
      chk("latency hold", bin0, 3);
      @(posedge clk);
      #1;
      chk("latency after", bin0, 6);

      cyc(10'b10_0000_0001, 1'b0);
      chk("prio top", bin1, 9);

      off = int'($urandom_range(0, 1023));
      for (int i = 0; i < 1024; i++) begin
         cyc(10'((i * 263 + off) % 1024), ($urandom_range(0, 31) == 0));
      end
      cyc(10'd0, 1'b0);
      cyc(10'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
